// File: rtl/dm_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the data memory and dm_arbiter.
// The arbiter attaches through the slave modport; the environment uses master.
interface dm_arbiter_if #(
    parameter int ADDR_W = 9
);
    logic              cpu_req;
    logic              cpu_we;
    logic [1:0]        cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_ack;
    logic              cpu_err;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_ack;

    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0]       rdata;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_err,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output rdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_err,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  rdata, busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin CPU/DMA arbiter for a single-port word memory, with
// read-modify-write for CPU byte/half stores and misalignment detection.
module dm_arbiter #(
    parameter int ADDR_W = 9
) (
    input  logic          clk,
    input  logic          rst,
    dm_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR} state_t;

    state_t            state_q, state_d;
    logic              last_cpu_q;
    logic              own_cpu_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;

    logic              grant_any, grant_cpu;
    logic              is_word, misaligned, is_rmw;
    logic [31:0]       merge_d;
    logic              ack, err, mem_we, busy;
    logic [31:0]       mem_wdata;

    assign grant_any = bus.cpu_req || bus.dma_req;
    assign grant_cpu = bus.cpu_req && (!bus.dma_req || !last_cpu_q);

    // DMA grants latch size 00, so every DMA access behaves as an aligned word
    assign is_word    = (size_q == 2'b00) || (size_q == 2'b11);
    assign misaligned = own_cpu_q &&
                        (((size_q == 2'b01) && addr_q[0]) ||
                         (is_word && (addr_q[1:0] != 2'b00)));
    assign is_rmw     = we_q && !is_word && !misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_any) state_d = ACCESS;
            ACCESS:  state_d = is_rmw ? RMW_WR : IDLE;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        merge_d = bus.mem_rdata;
        if (size_q == 2'b10) begin
            unique case (addr_q[1:0])
                2'd0: merge_d[7:0]   = wdata_q[7:0];
                2'd1: merge_d[15:8]  = wdata_q[7:0];
                2'd2: merge_d[23:16] = wdata_q[7:0];
                2'd3: merge_d[31:24] = wdata_q[7:0];
                default: ;
            endcase
        end else if (addr_q[1]) begin
            merge_d[31:16] = wdata_q[15:0];
        end else begin
            merge_d[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_cpu_q <= 1'b0;
            own_cpu_q  <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (state_q == IDLE && grant_any) begin
                last_cpu_q <= grant_cpu;
                own_cpu_q  <= grant_cpu;
                we_q       <= grant_cpu ? bus.cpu_we    : bus.dma_we;
                size_q     <= grant_cpu ? bus.cpu_size  : 2'b00;
                addr_q     <= grant_cpu ? bus.cpu_addr  : bus.dma_addr;
                wdata_q    <= grant_cpu ? bus.cpu_wdata : bus.dma_wdata;
            end
            if (state_q == ACCESS && !misaligned) begin
                if (!we_q)       rdata_q <= bus.mem_rdata;
                else if (is_rmw) merge_q <= merge_d;
            end
        end
    end

    always_comb begin
        ack       = 1'b0;
        err       = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            ACCESS: begin
                if (misaligned) begin
                    ack = 1'b1;
                    err = 1'b1;
                end else if (!we_q) begin
                    ack = 1'b1;
                end else if (!is_rmw) begin
                    ack       = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                end
            end
            RMW_WR: begin
                ack       = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = merge_q;
            end
            default: ;
        endcase
    end

    assign bus.cpu_ack   = ack && own_cpu_q;
    assign bus.dma_ack   = ack && !own_cpu_q;
    assign bus.cpu_err   = err;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = addr_q[ADDR_W-1:2];
    assign bus.mem_wdata = mem_wdata;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random CPU/DMA traffic checked
// against a transaction-level memory and round-robin model.
module tb_dm_arbiter;
    localparam int ADDR_W = 9;
    localparam int NW     = 1 << (ADDR_W - 2);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    dm_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem     [NW];
    logic [31:0] ref_mem [NW];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we)  mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pl_en)  mem[pl_idx]       <= pl_val;
    end

    int unsigned total = 0;
    int unsigned bad   = 0;

    bit                cp_pend = 0, cp_we = 0;
    logic [1:0]        cp_size = '0;
    logic [ADDR_W-1:0] cp_addr = '0;
    logic [31:0]       cp_wdata = '0;
    bit                dp_pend = 0, dp_we = 0;
    logic [ADDR_W-1:0] dp_addr = '0;
    logic [31:0]       dp_wdata = '0;
    bit                m_last_cpu = 0;
    logic [31:0]       m_rdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.cpu_req   = cp_pend;
        bus.cpu_we    = cp_we;
        bus.cpu_size  = cp_size;
        bus.cpu_addr  = cp_addr;
        bus.cpu_wdata = cp_wdata;
        bus.dma_req   = dp_pend;
        bus.dma_we    = dp_we;
        bus.dma_addr  = dp_addr;
        bus.dma_wdata = dp_wdata;
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        pl_idx = idx[6:0];
        pl_val = v;
        pl_en  = 1'b1;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic new_cpu();
        cp_pend  = 1;
        cp_we    = 1'($urandom_range(0, 1));
        cp_size  = 2'($urandom_range(0, 3));
        cp_addr  = ADDR_W'($urandom_range(0, 63));
        cp_wdata = $urandom;
    endtask

    task automatic new_dma();
        dp_pend  = 1;
        dp_we    = 1'($urandom_range(0, 1));
        dp_addr  = ADDR_W'($urandom_range(0, 63));
        dp_wdata = $urandom;
    endtask

    // One grant from IDLE through its ack, checked against the reference model.
    task automatic step(output bit win_cpu);
        bit                we, err, rmw, seen;
        logic [1:0]        sz;
        logic [ADDR_W-1:0] a;
        logic [31:0]       wd, word, lanes;
        int                idx, sh, lat, nwe;
        drive();
        win_cpu = cp_pend && (!dp_pend || !m_last_cpu);
        if (win_cpu) begin we = cp_we; sz = cp_size; a = cp_addr; wd = cp_wdata; end
        else         begin we = dp_we; sz = 2'b00;   a = dp_addr; wd = dp_wdata; end
        idx  = int'(a) / 4;
        err  = win_cpu && (((sz == 2'b01) && a[0]) ||
                           ((sz == 2'b00 || sz == 2'b11) && (int'(a) % 4 != 0)));
        rmw  = we && !err && (sz == 2'b01 || sz == 2'b10);
        word = ref_mem[idx];
        if (we && !err) begin
            if (sz == 2'b10)      begin sh = (int'(a) % 4) * 8;        lanes = 32'hFF << sh;   end
            else if (sz == 2'b01) begin sh = ((int'(a) / 2) % 2) * 16; lanes = 32'hFFFF << sh; end
            else                  begin sh = 0;                        lanes = '1;             end
            word = (word & ~lanes) | ((wd << sh) & lanes);
        end
        lat = 0; nwe = 0; seen = 0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.mem_we) nwe++;
            if (bus.cpu_ack || bus.dma_ack) begin
                seen = 1;
                check("who", 32'({bus.cpu_ack, bus.dma_ack}), win_cpu ? 32'd2 : 32'd1);
                check("err", 32'(bus.cpu_err), 32'(err));
                check("lat", 32'(lat), rmw ? 32'd3 : 32'd2);
                check("busy_hi", 32'(bus.busy), 32'd1);
            end
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
        check("we_pulses", 32'(nwe), (we && !err) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        ref_mem[idx] = word;
        m_last_cpu   = win_cpu;
        if (!we && !err) m_rdata = ref_mem[idx];
        check("mem", mem[idx], word);
        check("rdata", bus.rdata, m_rdata);
        check("busy_lo", 32'(bus.busy), 32'd0);
        if (win_cpu) cp_pend = 0;
        else         dp_pend = 0;
        drive();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_cack"}, 32'(bus.cpu_ack), 32'd0);
        check({tag, "_cerr"}, 32'(bus.cpu_err), 32'd0);
        check({tag, "_dack"}, 32'(bus.dma_ack), 32'd0);
        check({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_rdata"}, bus.rdata, 32'd0);
    endtask

    bit w, prev;

    initial begin
        rst = 1'b1;
        drive();
        #1;
        check_zero("rst");
        for (int i = 0; i < NW; i++) poke(i, $urandom);
        rst = 1'b0;

        // CPU/DMA tie: CPU wins first after reset
        poke(3, 32'h11223344);
        cp_pend = 1; cp_we = 0; cp_size = 2'b00; cp_addr = 9'h00C; cp_wdata = '0;
        dp_pend = 1; dp_we = 1; dp_addr = 9'h010; dp_wdata = 32'hCAFEBABE;
        step(w);
        check("tie_first_cpu", 32'(w), 32'd1);
        check("tie_rdata", bus.rdata, 32'h11223344);
        step(w);
        check("tie_second_dma", 32'(w), 32'd0);
        check("tie_mem4", mem[4], 32'hCAFEBABE);

        poke(2, 32'hAABBCCDD);
        cp_pend = 1; cp_we = 1; cp_size = 2'b10; cp_addr = 9'h009; cp_wdata = 32'h000000EE;
        step(w);
        check("sb_mem2", mem[2], 32'hAABBEEDD);

        poke(2, 32'hAABBCCDD);
        cp_pend = 1; cp_we = 1; cp_size = 2'b01; cp_addr = 9'h00A; cp_wdata = 32'h00001234;
        step(w);
        check("sh_mem2", mem[2], 32'h1234CCDD);
        cp_pend = 1; cp_we = 1; cp_size = 2'b01; cp_addr = 9'h00B; cp_wdata = 32'h00005678;
        step(w);
        check("sh_mis_mem2", mem[2], 32'h1234CCDD);

        // Both held continuously: grants must alternate
        prev = m_last_cpu;
        for (int i = 0; i < 8; i++) begin
            if (!cp_pend) new_cpu();
            if (!dp_pend) new_dma();
            step(w);
            check("alternate", 32'(w), 32'(!prev));
            prev = w;
        end
        while (cp_pend || dp_pend) step(w);

        for (int i = 0; i < 200; i++) begin
            if (!cp_pend && $urandom_range(0, 9) < 7) new_cpu();
            if (!dp_pend && $urandom_range(0, 9) < 5) new_dma();
            if (!cp_pend && !dp_pend) new_cpu();
            step(w);
        end
        while (cp_pend || dp_pend) step(w);

        // Reset asserted during the RMW write cycle
        poke(2, 32'hAABBCCDD);
        cp_pend = 1; cp_we = 1; cp_size = 2'b10; cp_addr = 9'h009; cp_wdata = 32'h00000055;
        drive();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rmw_we_before_rst", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check_zero("midrmw");
        @(posedge clk);
        #1;
        check("midrmw_mem2", mem[2], 32'hAABBCCDD);
        rst        = 1'b0;
        m_last_cpu = 0;
        m_rdata    = '0;
        step(w);
        check("after_rst_mem2", mem[2], 32'hAABB55DD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
